// File: rtl/scalar_mul_accum_if.sv
// Purpose: handshake bundle between the ScalarMul group accumulator and its neighbours.
// Latency: none, this file holds wires only.
// Backpressure: in_ready grants upstream groups on credit; out_ready pops the result FIFO.
//
// Ports/signals:
//   in_valid/in_ready/prod/clear  upstream side: vector-set handshake, sink word, flush
//   out_data/out_ovf/out_valid/out_ready  downstream side: group-sum result stream
// master = the side that drives the inputs and consumes results; slave = accumulator.
interface scalar_mul_accum_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     prod;
    logic                 clear;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_ovf;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_valid, prod, clear, out_ready,
        input  in_ready, out_data, out_ovf, out_valid
    );

    modport slave (
        input  in_valid, prod, clear, out_ready,
        output in_ready, out_data, out_ovf, out_valid
    );
endinterface

// File: rtl/scalar_mul_accum.sv
// Purpose: sum LEN ScalarMul sink words per group into a wide result, buffered in a FIFO.
// Latency: last accepted element at cycle t -> out_valid at t+LATENCY+1 (FIFO empty before).
// Backpressure: a new upstream group is only admitted when a FIFO slot is reserved for it.
//
// Ports (scalar_mul_accum):
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   bus.in_valid/in_ready  upstream vector-set handshake (accept = in_valid & in_ready)
//   bus.prod             ScalarMul sink word, meaningful only LATENCY cycles after an accept
//   bus.clear            synchronous flush of pipe, counters, accumulator and FIFO
//   bus.out_data/out_ovf/out_valid/out_ready  head-of-FIFO result stream
//
// scalar_mul_accum_fifo: small first-in first-out store; push and pop may share a cycle,
// including when full (the popped slot is reused) or empty (pop ignored).

module scalar_mul_accum_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    // When full, a push is still taken if the head leaves in the same cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module scalar_mul_accum #(
    parameter int WIDTH      = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int LATENCY    = 35,
    parameter int LEN        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    scalar_mul_accum_if.slave  bus
);
    localparam int LW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = CW + 1;

    logic [LATENCY-1:0]   vpipe;
    logic [LW-1:0]        cnt;
    logic [LW-1:0]        icnt;
    logic [CW-1:0]        pend;
    logic [CW-1:0]        fifo_count;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf_acc;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 add_ovf;
    logic                 ovf_new;
    logic                 accept;
    logic                 sample;
    logic                 last;
    logic                 push;
    logic                 pend_inc;
    logic [ACC_WIDTH:0]   head;

    // A group may start only if every group already admitted (pushed or still in
    // flight) plus this one fits in the FIFO; later elements of a started group
    // ride on the credit the first element took.
    assign bus.in_ready = !reset && !bus.clear &&
                          ((icnt != '0) ||
                           (({1'b0, fifo_count} + {1'b0, pend}) < PW'(FIFO_DEPTH)));

    assign accept   = bus.in_valid && bus.in_ready;
    // The valid pipe marks which sink words belong to accepted sets.
    assign sample   = vpipe[LATENCY-1] && !bus.clear;
    assign prod_ext = {{(ACC_WIDTH - WIDTH){bus.prod[WIDTH-1]}}, bus.prod};
    assign sum      = acc + prod_ext;
    // Signed overflow: operands agree in sign but the result does not.
    assign add_ovf  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    assign ovf_new  = ovf_acc || add_ovf;
    assign last     = (cnt == LW'(LEN - 1));
    assign push     = sample && last;
    assign pend_inc = accept && (icnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vpipe   <= '0;
            cnt     <= '0;
            icnt    <= '0;
            pend    <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (bus.clear) begin
            vpipe   <= '0;
            cnt     <= '0;
            icnt    <= '0;
            pend    <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else begin
            vpipe[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vpipe[i] <= vpipe[i-1];

            if (sample) begin
                if (last) begin
                    acc     <= '0;
                    ovf_acc <= 1'b0;
                    cnt     <= '0;
                end else begin
                    acc     <= sum;
                    ovf_acc <= ovf_new;
                    cnt     <= cnt + 1'b1;
                end
            end

            if (accept) icnt <= (icnt == LW'(LEN - 1)) ? '0 : icnt + 1'b1;

            case ({pend_inc, push})
                2'b10:   pend <= pend + 1'b1;
                2'b01:   pend <= pend - 1'b1;
                default: pend <= pend;
            endcase
        end
    end

    scalar_mul_accum_fifo #(
        .W     (ACC_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clock),
        .rst      (reset),
        .clr      (bus.clear),
        .push     (push),
        .push_dat ({ovf_new, sum}),
        .pop      (bus.out_ready),
        .head_dat (head),
        .count    (fifo_count)
    );

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = head[ACC_WIDTH-1:0];
    assign bus.out_ovf   = head[ACC_WIDTH];
endmodule

// File: tb/tb_scalar_mul_accum.sv
module tb_scalar_mul_accum;
    localparam int LAT   = 35;
    localparam int LEN   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] src_val = 16'h5A5A;
    logic [15:0] kpipe [LAT];
    logic [15:0] prod;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [40:0] q40 [$];
    logic [17:0] q17 [$];

    always #5 clock = ~clock;

    scalar_mul_accum_if #(.WIDTH(16), .ACC_WIDTH(40)) bus40 ();
    scalar_mul_accum_if #(.WIDTH(16), .ACC_WIDTH(17)) bus17 ();

    assign bus40.in_valid  = in_valid;
    assign bus40.prod      = prod;
    assign bus40.clear     = clear;
    assign bus40.out_ready = out_ready;
    assign bus17.in_valid  = in_valid;
    assign bus17.prod      = prod;
    assign bus17.clear     = clear;
    assign bus17.out_ready = out_ready;

    scalar_mul_accum #(.WIDTH(16), .ACC_WIDTH(40), .LATENCY(LAT), .LEN(LEN), .FIFO_DEPTH(DEPTH))
        dut (.clock(clock), .reset(reset), .bus(bus40));
    scalar_mul_accum #(.WIDTH(16), .ACC_WIDTH(17), .LATENCY(LAT), .LEN(LEN), .FIFO_DEPTH(DEPTH))
        dut17 (.clock(clock), .reset(reset), .bus(bus17));

    // ScalarMul stand-in: free-running delay line with no handshake.
    always @(posedge clock) begin
        kpipe[0] <= src_val;
        for (int i = 1; i < LAT; i++) kpipe[i] <= kpipe[i-1];
        cyc <= cyc + 1;
    end
    assign prod = kpipe[LAT-1];

    // Record every result that will be popped at the coming edge.
    always @(negedge clock) begin
        if (!reset && !clear && out_ready) begin
            if (bus40.out_valid) q40.push_back({bus40.out_ovf, bus40.out_data});
            if (bus17.out_valid) q17.push_back({bus17.out_ovf, bus17.out_data});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one vector set until accepted; acc_cyc is the cycle it was accepted in.
    task automatic send_elem(input logic [15:0] v, output int acc_cyc, output int waited);
        int n = 0;
        in_valid = 1'b1;
        src_val  = v;
        while (!bus40.in_ready && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, value %0d", n, v);
            $fatal(1, "handshake stuck");
        end
        acc_cyc  = cyc;
        waited   = n;
        step();
        in_valid = 1'b0;
        src_val  = 16'h5A5A;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k = 0;
        while (q40.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (bus40.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus40.out_valid); end
        checks++; if (bus40.out_data !== 40'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus40.out_data); end
        checks++; if (bus40.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b want 0", bus40.out_ovf); end
        checks++; if (bus40.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus40.in_ready); end
        reset = 1'b0;
        #1;
        checks++; if (bus40.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", bus40.in_ready); end
        step();
    endtask

    task automatic test_basic();
        int c, w;
        out_ready = 1'b1;
        q40.delete(); q17.delete();
        send_elem(16'd1, c, w);
        send_elem(16'd2, c, w);
        send_elem(16'd3, c, w);
        send_elem(16'd4, c, w);
        while (cyc < c + LAT) step();
        checks++; if (bus40.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0 at t+LAT", bus40.out_valid); end
        step();
        checks++; if (bus40.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1 at t+LAT+1", bus40.out_valid); end
        checks++; if (bus40.out_data !== 40'd10) begin errors++; $display("FAIL basic_data: got %0d want 10", bus40.out_data); end
        checks++; if (bus40.out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", bus40.out_ovf); end
        step();
        checks++; if (bus40.out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b want 0 after pop", bus40.out_valid); end
    endtask

    task automatic test_signed();
        int c, w;
        out_ready = 1'b1;
        q40.delete(); q17.delete();
        send_elem(16'hFFFB, c, w);   // -5
        send_elem(16'h0003, c, w);
        send_elem(16'h7FFF, c, w);
        send_elem(16'h8000, c, w);   // -32768
        wait_results(1, 100);
        step();
        // -5 + 3 + 32767 - 32768 = -3
        checks++; if (q40.size() !== 1) begin errors++; $display("FAIL signed_count: got %0d want 1", q40.size()); end
        checks++; if (q40[0] !== {1'b0, 40'hFF_FFFF_FFFD}) begin errors++; $display("FAIL signed_data40: got %h want 0ffffffffffd", q40[0]); end
        checks++; if (q17[0] !== {1'b0, 17'h1FFFD}) begin errors++; $display("FAIL signed_data17: got %h want 01fffd", q17[0]); end
    endtask

    task automatic test_backpressure();
        int c, w;
        int stalls = 0;
        int ready_seen = 0;
        out_ready = 1'b0;
        q40.delete(); q17.delete();
        for (int g = 1; g <= 4; g++)
            for (int i = 1; i <= 4; i++) begin
                send_elem(16'(g * i), c, w);
                stalls += w;
            end
        checks++; if (stalls !== 0) begin errors++; $display("FAIL bp_first_four_stalled: got %0d stall cycles want 0", stalls); end
        in_valid = 1'b1;
        src_val  = 16'd5;
        #1;
        checks++; if (bus40.in_ready !== 1'b0) begin errors++; $display("FAIL bp_group5_ready: got %b want 0", bus40.in_ready); end
        for (int k = 0; k < 60; k++) begin
            if (bus40.in_ready) ready_seen++;
            step();
        end
        checks++; if (ready_seen !== 0) begin errors++; $display("FAIL bp_ready_leak: ready for %0d cycles want 0", ready_seen); end
        checks++; if (bus40.out_valid !== 1'b1 || bus40.out_data !== 40'd10) begin errors++; $display("FAIL bp_head: got valid %b data %0d want 1/10", bus40.out_valid, bus40.out_data); end
        checks++; if (q40.size() !== 0) begin errors++; $display("FAIL bp_no_pop: got %0d pops want 0", q40.size()); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send_elem(16'(5 * i), c, w);
        wait_results(5, 200);
        step();
        checks++; if (q40.size() !== 5) begin errors++; $display("FAIL bp_count: got %0d want 5", q40.size()); end
        for (int k = 0; k < 5 && k < q40.size(); k++) begin
            checks++;
            if (q40[k] !== {1'b0, 40'(10 * (k + 1))}) begin
                errors++; $display("FAIL bp_order[%0d]: got %h want %0d", k, q40[k], 10 * (k + 1));
            end
        end
    endtask

    task automatic test_overflow();
        int c, w;
        out_ready = 1'b1;
        q40.delete(); q17.delete();
        repeat (4) send_elem(16'h7FFF, c, w);
        repeat (4) send_elem(16'h0001, c, w);
        wait_results(2, 100);
        step();
        checks++; if (q17.size() !== 2) begin errors++; $display("FAIL ovf_count: got %0d want 2", q17.size()); end
        checks++; if (q17[0] !== {1'b1, 17'h1FFFC}) begin errors++; $display("FAIL ovf_wrap17: got %h want 11fffc", q17[0]); end
        checks++; if (q17[1] !== {1'b0, 17'd4}) begin errors++; $display("FAIL ovf_next_group: got %h want 000004", q17[1]); end
        checks++; if (q40[0] !== {1'b0, 40'h1FFFC}) begin errors++; $display("FAIL ovf_wide40: got %h want 1fffc no ovf", q40[0]); end
    endtask

    task automatic test_clear();
        int c, w;
        out_ready = 1'b1;
        q40.delete(); q17.delete();
        send_elem(16'd7, c, w);
        send_elem(16'd7, c, w);
        repeat (5) step();
        clear    = 1'b1;
        in_valid = 1'b1;
        src_val  = 16'd100;
        #1;
        checks++; if (bus40.in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b want 0", bus40.in_ready); end
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        src_val  = 16'h5A5A;
        repeat (LAT + 10) step();
        checks++; if (q40.size() !== 0 || bus40.out_valid !== 1'b0) begin errors++; $display("FAIL clear_flush: got %0d results valid %b want 0/0", q40.size(), bus40.out_valid); end
        repeat (4) send_elem(16'd1, c, w);
        wait_results(1, 100);
        repeat (10) step();
        checks++; if (q40.size() !== 1) begin errors++; $display("FAIL clear_after_count: got %0d want 1", q40.size()); end
        checks++; if (q40[0] !== {1'b0, 40'd4}) begin errors++; $display("FAIL clear_after_data: got %h want 4", q40[0]); end
    endtask

    task automatic test_async_reset();
        int c, w;
        out_ready = 1'b0;
        q40.delete(); q17.delete();
        repeat (4) send_elem(16'd3, c, w);
        repeat (4) send_elem(16'd5, c, w);
        repeat (LAT + 5) step();
        checks++; if (bus40.out_valid !== 1'b1 || bus40.out_data !== 40'd12) begin errors++; $display("FAIL areset_pre_head: got valid %b data %0d want 1/12", bus40.out_valid, bus40.out_data); end
        send_elem(16'd9, c, w);
        send_elem(16'd9, c, w);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bus40.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", bus40.out_valid); end
        checks++; if (bus40.out_data !== 40'd0 || bus40.in_ready !== 1'b0) begin errors++; $display("FAIL areset_state: got data %0d ready %b want 0/0", bus40.out_data, bus40.in_ready); end
        repeat (2) step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        repeat (4) send_elem(16'd2, c, w);
        wait_results(1, 100);
        repeat (LAT) step();
        checks++; if (q40.size() !== 1) begin errors++; $display("FAIL areset_count: got %0d want 1", q40.size()); end
        checks++; if (q40[0] !== {1'b0, 40'd8}) begin errors++; $display("FAIL areset_data: got %h want 8", q40[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_overflow();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
